// File: rtl/pipe_datapath.sv
// pipe_datapath: two-stage (RD -> EX) register-file datapath with a
// single-entry EX stage and a valid/ready handshake on both sides.
// RD captures register operands at accept; EX shifts, runs the ALU and
// retires into C / Z_out while writing the register file.
// Optional feature: define PIPE_DATAPATH_FWD_EN to bypass the retiring EX
// write data into RD reads. Without it, a read-after-write against the op
// in EX holds in_ready low for one cycle instead.
module pipe_datapath #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int PC_W   = 8,
   localparam int AW    = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [AW-1:0]     reada,
   input  logic [AW-1:0]     readb,
   input  logic [AW-1:0]     writenum,
   input  logic              wb_en,
   input  logic [1:0]        shift,
   input  logic [1:0]        ALUop,
   input  logic              asel,
   input  logic              bsel,
   input  logic [1:0]        vsel,
   input  logic [DATA_W-1:0] imm,
   input  logic [DATA_W-1:0] mdata,
   input  logic [PC_W-1:0]   PC,
   input  logic              loads,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] C,
   output logic [2:0]        Z_out
);

   localparam int MSB = DATA_W - 1;

   // Register file
   logic [DATA_W-1:0] regs_q [NREG];

   // EX stage operand / control registers
   logic              ex_full_q;
   logic [DATA_W-1:0] ex_a_q, ex_b_q, ex_imm_q, ex_mdata_q;
   logic [PC_W-1:0]   ex_pc_q;
   logic [AW-1:0]     ex_wn_q;
   logic              ex_wb_q, ex_asel_q, ex_bsel_q, ex_loads_q;
   logic [1:0]        ex_shift_q, ex_aluop_q, ex_vsel_q;

   // Result side
   logic [DATA_W-1:0] c_q;
   logic [2:0]        flags_q;
   logic              out_valid_q;
   // Holds in_ready low until the first edge after reset release
   logic              rdy_en_q;

   logic              accept, retire, hazard;
   logic [DATA_W-1:0] rd_a, rd_b;
   logic [DATA_W-1:0] a_op, b_mux, b_op, alu_res, wb_data;
   logic              alu_v;

   assign retire    = ex_full_q & (~out_valid_q | out_ready);
   assign accept    = in_valid & in_ready;
   assign C         = c_q;
   assign Z_out     = flags_q;
   assign out_valid = out_valid_q;

`ifdef PIPE_DATAPATH_FWD_EN
   assign hazard = 1'b0;

   // Register read with bypass of the value being written on this edge
   always_comb begin
      rd_a = regs_q[reada];
      rd_b = regs_q[readb];
      if (retire && ex_wb_q && (ex_wn_q == reada)) rd_a = wb_data;
      if (retire && ex_wb_q && (ex_wn_q == readb)) rd_b = wb_data;
   end
`else
   // A valid input reading the EX destination waits for that write to land
   assign hazard = in_valid & ex_full_q & ex_wb_q &
                   ((ex_wn_q == reada) | (ex_wn_q == readb));

   // Plain register read; hazards are resolved by stalling
   always_comb begin
      rd_a = regs_q[reada];
      rd_b = regs_q[readb];
   end
`endif

   assign in_ready = rdy_en_q & (~ex_full_q | retire) & ~hazard;

   // B operand: immediate or register, then the shifter
   always_comb begin
      a_op  = ex_asel_q ? '0 : ex_a_q;
      b_mux = ex_bsel_q ? ex_imm_q : ex_b_q;
      b_op  = b_mux;
      unique case (ex_shift_q)
         2'b00: b_op = b_mux;
         2'b01: b_op = {b_mux[MSB-1:0], 1'b0};
         2'b10: b_op = {1'b0, b_mux[MSB:1]};
         2'b11: b_op = {b_mux[MSB], b_mux[MSB:1]};
      endcase
   end

   // ALU and signed-overflow detect (overflow only meaningful for add/sub)
   always_comb begin
      alu_res = '0;
      alu_v   = 1'b0;
      unique case (ex_aluop_q)
         2'b00: begin
            alu_res = a_op + b_op;
            alu_v   = (a_op[MSB] == b_op[MSB]) & (alu_res[MSB] != a_op[MSB]);
         end
         2'b01: begin
            alu_res = a_op - b_op;
            alu_v   = (a_op[MSB] != b_op[MSB]) & (alu_res[MSB] != a_op[MSB]);
         end
         2'b10: alu_res = a_op & b_op;
         2'b11: alu_res = ~b_op;
      endcase
   end

   // Write-back data select; C and flags always take the ALU result
   always_comb begin
      wb_data = alu_res;
      unique case (ex_vsel_q)
         2'b11: wb_data = ex_mdata_q;
         2'b10: wb_data = ex_imm_q;
         2'b01: wb_data = DATA_W'(ex_pc_q);
         2'b00: wb_data = alu_res;
      endcase
   end

   // Register file write at EX retire
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (retire && ex_wb_q) begin
         regs_q[ex_wn_q] <= wb_data;
      end
   end

   // RD -> EX capture on accept; EX empties when it retires
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_full_q  <= 1'b0;
         ex_a_q     <= '0;
         ex_b_q     <= '0;
         ex_imm_q   <= '0;
         ex_mdata_q <= '0;
         ex_pc_q    <= '0;
         ex_wn_q    <= '0;
         ex_wb_q    <= 1'b0;
         ex_asel_q  <= 1'b0;
         ex_bsel_q  <= 1'b0;
         ex_loads_q <= 1'b0;
         ex_shift_q <= '0;
         ex_aluop_q <= '0;
         ex_vsel_q  <= '0;
      end else begin
         if (accept) begin
            ex_full_q  <= 1'b1;
            ex_a_q     <= rd_a;
            ex_b_q     <= rd_b;
            ex_imm_q   <= imm;
            ex_mdata_q <= mdata;
            ex_pc_q    <= PC;
            ex_wn_q    <= writenum;
            ex_wb_q    <= wb_en;
            ex_asel_q  <= asel;
            ex_bsel_q  <= bsel;
            ex_loads_q <= loads;
            ex_shift_q <= shift;
            ex_aluop_q <= ALUop;
            ex_vsel_q  <= vsel;
         end else if (retire) begin
            ex_full_q  <= 1'b0;
         end
      end
   end

   // Result register, status flags and output valid
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c_q         <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
         rdy_en_q    <= 1'b0;
      end else begin
         rdy_en_q <= 1'b1;
         if (retire) begin
            c_q         <= alu_res;
            out_valid_q <= 1'b1;
            if (ex_loads_q) flags_q <= {alu_v, alu_res[MSB], (alu_res == '0)};
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: doc/pipe_datapath.md
PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
REQ-001 Parameter DATA_W, 16, datapath and register width (>=8).
REQ-002 Parameter NREG, 8, register-file depth (power of 2, >=2); AW = log2(NREG).
REQ-003 Parameter PC_W, 8, PC width (<=DATA_W); zero-extended into the write-data mux.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1 / in_ready  out  1  operation handshake; accept = in_valid & in_ready.
REQ-007 reada, readb  in  AW  source registers, both read in the same cycle.
REQ-008 writenum  in  AW / wb_en  in  1  destination register and write enable.
REQ-009 shift  in  2  B-operand shift: 00 none, 01 lsl1, 10 lsr1 (zero fill), 11 asr1.
REQ-010 ALUop  in  2  00 A+B, 01 A-B, 10 A&B, 11 ~B.
REQ-011 asel  in  1 (1: A=0) / bsel  in  1 (1: B=imm).
REQ-012 vsel  in  2  write data: 11 mdata, 10 imm, 01 {0,PC}, 00 ALU result.
REQ-013 imm, mdata  in  DATA_W / PC  in  PC_W  operands sampled at accept.
REQ-014 loads  in  1  update status flags for this operation.
REQ-015 out_ready  in  1 / out_valid  out  1  result handshake.
REQ-016 C  out  DATA_W  result register / Z_out  out  3  {V,N,Z} status register.

Function
REQ-017 Two stages: RD (register read, captured into operand regs at accept), EX (shift+ALU, captured into C at EX retire).
REQ-018 Latency: op accepted at edge k SHALL present C and out_valid=1 after edge k+1.
REQ-019 EX retires on the edge where EX holds an op and (!out_valid | out_ready); at that edge: C loads, out_valid sets, regfile writes if wb_en, Z_out loads if loads.
REQ-020 out_valid SHALL clear on out_ready with no retiring op; C and Z_out hold while out_valid & !out_ready.
REQ-021 in_ready = !EX_full | EX retires this cycle (single-entry skid; full throughput with out_ready=1).
REQ-022 Arithmetic modulo 2^DATA_W; Z = result==0; N = result MSB; V = signed overflow for ALUop 00/01, 0 otherwise.
REQ-023 Flags and C SHALL reflect the ALU result regardless of vsel; vsel selects only regfile write data.
REQ-024 Register write and read of the same register on the same edge: reader gets the newly written value.
REQ-025 No write when wb_en=0; registers otherwise hold indefinitely.

Reset
REQ-026 reset_n low: all NREG registers, operand regs, C, Z_out SHALL be 0; out_valid=0; EX empty; in_ready=1 one cycle after release.
REQ-027 Reset mid-operation SHALL discard in-flight ops with no register write.

Configuration
REQ-028 Macro PIPE_DATAPATH_FWD_EN defined: RD reads bypass the retiring EX write data when reada/readb == EX writenum & wb_en; in_ready per REQ-021.
REQ-029 Macro undefined: no bypass; in_ready SHALL drop for one cycle when a valid input reads a register written by the op in EX, which adds one bubble.

Verification
REQ-030 Reset, then ops with reada=readb=0..NREG-1 -> C=0, Z_out=001, out_valid pulses after 2 edges.
REQ-031 Write R1=5, R2=7 (vsel=10), then add R1+R2 into R3 -> C=12, Z_out=000; then sub R3-R3 loads=1 -> C=0, Z_out=001.
REQ-032 DATA_W=16: 0x7FFF+1, loads=1 -> C=0x8000, Z_out=110; asr1 of B=0x8000 via ~ -> verify shift table.
REQ-033 Back-to-back dependent ops (R1=3 then R2=R1+R1): FWD_EN -> C=6, no bubble; undefined -> C=6, in_ready low 1 cycle.
REQ-034 Hold out_ready=0 for 3 cycles with two ops queued -> C/Z_out stable, in_ready=0, no op lost; release -> results in order.
REQ-035 Assert reset_n low mid-stream with wb_en op in EX -> target register stays 0, out_valid=0 immediately.
